// File: rtl/chn_ep_arb_pkg.sv
// Shared types and helpers for the TRN tx endpoint arbiter.
package chn_ep_arb_pkg;

  // Token FSM states
  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Ceiling log2, never below 1 so single-bit indices stay legal
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/chn_ep_arb_rr_pick.sv
// Round-robin picker: first requester strictly after 'last', wrapping to 'last' itself.
module chn_ep_arb_rr_pick
  import chn_ep_arb_pkg::*;
#(
  parameter int unsigned NCHN = 2,
  parameter int unsigned IW   = clog2(NCHN)
) (
  input  logic [NCHN-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   next,
  output logic            any_req
);

  int unsigned cand;

  // Scan farthest-first so the nearest requester in RR order wins; wrap is explicit
  always_comb begin
    any_req = |req;
    next    = last;
    cand    = 0;
    for (int unsigned k = NCHN; k > 0; k--) begin
      cand = 32'(last) + k;
      if (cand >= NCHN) cand = cand - NCHN;
      if (req[IW'(cand)]) next = IW'(cand);
    end
  end

endmodule

// File: rtl/chn_ep_arb.sv
// TRN tx endpoint arbiter: one ownership token circulated round-robin among channels.
module chn_ep_arb
  import chn_ep_arb_pkg::*;
#(
  parameter int unsigned NCHN     = 2,
  parameter int unsigned PARK_CYC = 4,
  parameter int unsigned GRANT_TO = 256
) (
  input  logic                   pcie_clk,
  input  logic                   pcie_rst,
  input  logic [NCHN-1:0]        chn_reqep,
  input  logic [NCHN-1:0]        chn_drvn,
  output logic [NCHN-1:0]        chn_trn,
  output logic [clog2(NCHN)-1:0] grant_idx,
  output logic                   err_bad_drv,
  output logic                   err_timeout
);

  localparam int unsigned IW = clog2(NCHN);
  localparam int unsigned CW = clog2((PARK_CYC > GRANT_TO) ? PARK_CYC : GRANT_TO) + 1;
  localparam logic [CW-1:0] CMAX     = {CW{1'b1}};
  localparam logic [CW-1:0] PARK_LIM = CW'(PARK_CYC);
  localparam logic [CW-1:0] GTO_LIM  = CW'(GRANT_TO);

  arb_state_e      state_q, state_d;
  logic [NCHN-1:0] trn_d;
  logic [IW-1:0]   idx_d, pick_idx, rot_idx;
  logic [CW-1:0]   park_cnt, park_d, wait_cnt, wait_d;
  logic            to_d, pick_any, hold_req, hold_drv, bad_drv_c;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  chn_ep_arb_rr_pick #(.NCHN(NCHN), .IW(IW)) u_pick (
    .req     (chn_reqep),
    .last    (grant_idx),
    .next    (pick_idx),
    .any_req (pick_any)
  );

  assign rot_idx   = (grant_idx == IW'(NCHN - 1)) ? '0 : grant_idx + IW'(1);
  assign hold_req  = chn_reqep[grant_idx];
  assign hold_drv  = chn_drvn[grant_idx];
  assign bad_drv_c = |(chn_drvn & ~chn_trn);

  // Next-state, token and counter decode
  always_comb begin
    state_d = state_q;
    trn_d   = chn_trn;
    idx_d   = grant_idx;
    park_d  = park_cnt;
    wait_d  = wait_cnt;
    to_d    = 1'b0;
    case (state_q)
      ST_ARB: begin
        idx_d   = pick_any ? pick_idx : rot_idx;
        trn_d   = NCHN'(1) << idx_d;
        park_d  = '0;
        wait_d  = '0;
        state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (hold_drv) begin
          state_d = ST_BUSY;
        end else if (!hold_req && park_cnt >= PARK_LIM) begin
          state_d = ST_RELEASE;
          trn_d   = '0;
        end else if (hold_req && wait_cnt >= GTO_LIM) begin
          state_d = ST_RELEASE;
          trn_d   = '0;
          to_d    = 1'b1;
        end else begin
          wait_d = sat_inc(wait_cnt);
          park_d = hold_req ? '0 : sat_inc(park_cnt);
        end
      end
      ST_BUSY: begin
        if (!hold_drv) begin
          state_d = ST_RELEASE;
          trn_d   = '0;
        end
      end
      ST_RELEASE: begin
        state_d = ST_ARB;
      end
      default: begin
        state_d = ST_ARB;
        trn_d   = '0;
      end
    endcase
  end

  // State, token, counters and error flags
  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state_q     <= ST_ARB;
      chn_trn     <= '0;
      grant_idx   <= IW'(NCHN - 1);
      park_cnt    <= '0;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      err_bad_drv <= 1'b0;
    end else begin
      state_q     <= state_d;
      chn_trn     <= trn_d;
      grant_idx   <= idx_d;
      park_cnt    <= park_d;
      wait_cnt    <= wait_d;
      err_timeout <= to_d;
      err_bad_drv <= err_bad_drv | bad_drv_c;
    end
  end

endmodule
